// File: rtl/soma_vm_arbiter.sv
// Arbiter sharing the single-port soma Vm SRAM between the soma datapath and the configurator.
// Latency: writes and grants are combinational (SRAM commits at edge); read data returns 1 cycle after grant.
// Backpressure: soma has fixed priority; a pending config request is forced through after STARVE_MAX denials.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   soma_vm_*                  soma write/read requests; soma_vm_stall asks soma to hold them
//   soma_vm_rvld/rdata         soma read return (1 cycle after grant)
//   config_soma_vm_*           config write/read requests; config_stall asks config to hold them
//   config_rvld/soma_vm_rdata  config read return (1 cycle after grant)
//   mem_*                      single-port SRAM interface, 1-cycle synchronous read
module soma_vm_arbiter #(
  parameter int NNW        = 12,
  parameter int VW         = 20,
  parameter int STARVE_MAX = 4,
  parameter int SCW        = 3
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           soma_vm_we,
  input  logic [NNW-1:0] soma_vm_waddr,
  input  logic [VW-1:0]  soma_vm_wdata,
  input  logic           soma_vm_re,
  input  logic [NNW-1:0] soma_vm_raddr,
  output logic           soma_vm_stall,
  output logic           soma_vm_rvld,
  output logic [VW-1:0]  soma_vm_rdata,
  input  logic           config_soma_vm_we,
  input  logic [NNW-1:0] config_soma_vm_waddr,
  input  logic [VW-1:0]  config_soma_vm_wdata,
  input  logic           config_soma_vm_re,
  input  logic [NNW-1:0] config_soma_vm_raddr,
  output logic           config_stall,
  output logic           config_rvld,
  output logic [VW-1:0]  config_soma_vm_rdata,
  output logic           mem_en,
  output logic           mem_we,
  output logic [NNW-1:0] mem_addr,
  output logic [VW-1:0]  mem_wdata,
  input  logic [VW-1:0]  mem_rdata
);

  typedef enum logic [1:0] {
    TAG_NONE = 2'd0,
    TAG_SOMA = 2'd1,
    TAG_CFG  = 2'd2
  } rd_tag_e;

  localparam logic [SCW-1:0] STARVE_LIM = SCW'(STARVE_MAX);

  logic [SCW-1:0] starve_cnt_q, starve_cnt_d;
  rd_tag_e        rd_tag_q, rd_tag_d;
  logic           soma_wr_done_q, soma_wr_done_d;

  logic soma_wr_pend;
  logic soma_req;
  logic cfg_req;
  logic force_cfg;
  logic cfg_gnt;
  logic soma_gnt;
  logic soma_split;
  logic soma_rd_gnt;
  logic cfg_rd_gnt;

  // A soma write already committed during a write-then-read split is not
  // repeated while soma holds its request for the read half.
  assign soma_wr_pend = soma_vm_we & ~soma_wr_done_q;
  assign soma_req     = soma_wr_pend | soma_vm_re;
  assign cfg_req      = config_soma_vm_we | config_soma_vm_re;

  assign force_cfg = cfg_req & (starve_cnt_q == STARVE_LIM);
  assign cfg_gnt   = force_cfg | (cfg_req & ~soma_req);
  assign soma_gnt  = soma_req & ~cfg_gnt;

  // Soma write goes first; a simultaneous read waits for a later grant.
  assign soma_split  = soma_gnt & soma_wr_pend & soma_vm_re;
  assign soma_rd_gnt = soma_gnt & ~soma_wr_pend;
  // A combined config write+read is treated as a write; the read is dropped.
  assign cfg_rd_gnt  = cfg_gnt & ~config_soma_vm_we & config_soma_vm_re;

  assign soma_vm_stall = soma_req & (cfg_gnt | soma_split);
  assign config_stall  = cfg_req & ~cfg_gnt;

  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (cfg_gnt) begin
      mem_en    = 1'b1;
      mem_we    = config_soma_vm_we;
      mem_addr  = config_soma_vm_we ? config_soma_vm_waddr : config_soma_vm_raddr;
      mem_wdata = config_soma_vm_wdata;
    end else if (soma_gnt) begin
      mem_en    = 1'b1;
      mem_we    = soma_wr_pend;
      mem_addr  = soma_wr_pend ? soma_vm_waddr : soma_vm_raddr;
      mem_wdata = soma_vm_wdata;
    end
  end

  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (cfg_gnt || !cfg_req) begin
      starve_cnt_d = '0;
    end else if (starve_cnt_q != STARVE_LIM) begin
      starve_cnt_d = starve_cnt_q + SCW'(1);
    end
  end

  always_comb begin
    soma_wr_done_d = soma_wr_done_q;
    if (soma_split) begin
      soma_wr_done_d = 1'b1;
    end else if (soma_rd_gnt || !soma_vm_we) begin
      soma_wr_done_d = 1'b0;
    end
  end

  always_comb begin
    rd_tag_d = TAG_NONE;
    if (cfg_rd_gnt) begin
      rd_tag_d = TAG_CFG;
    end else if (soma_rd_gnt) begin
      rd_tag_d = TAG_SOMA;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt_q   <= '0;
      rd_tag_q       <= TAG_NONE;
      soma_wr_done_q <= 1'b0;
    end else begin
      starve_cnt_q   <= starve_cnt_d;
      rd_tag_q       <= rd_tag_d;
      soma_wr_done_q <= soma_wr_done_d;
    end
  end

  // Read data is steered to the owner of last cycle's read; the other side sees 0.
  assign soma_vm_rvld         = (rd_tag_q == TAG_SOMA);
  assign config_rvld          = (rd_tag_q == TAG_CFG);
  assign soma_vm_rdata        = soma_vm_rvld ? mem_rdata : '0;
  assign config_soma_vm_rdata = config_rvld  ? mem_rdata : '0;

endmodule

// File: tb/tb_soma_vm_arbiter.sv
module tb_soma_vm_arbiter;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // DUT A: default STARVE_MAX=4
  logic        s_we, s_re, c_we, c_re;
  logic [11:0] s_waddr, s_raddr, c_waddr, c_raddr;
  logic [19:0] s_wdata, c_wdata;
  logic        s_stall, s_rvld, c_stall, c_rvld;
  logic [19:0] s_rdata, c_rdata;
  logic        m_en, m_we;
  logic [11:0] m_addr;
  logic [19:0] m_wdata, m_rdata;

  // DUT Z: STARVE_MAX=0, reads only
  logic        z_s_re, z_c_re;
  logic [11:0] z_s_raddr, z_c_raddr;
  logic        z_s_stall, z_s_rvld, z_c_stall, z_c_rvld;
  logic [19:0] z_s_rdata, z_c_rdata;
  logic        z_en, z_we;
  logic [11:0] z_addr;
  logic [19:0] z_wdata, z_rdata;

  soma_vm_arbiter u_dut (
    .clk(clk), .rst_n(rst_n),
    .soma_vm_we(s_we), .soma_vm_waddr(s_waddr), .soma_vm_wdata(s_wdata),
    .soma_vm_re(s_re), .soma_vm_raddr(s_raddr),
    .soma_vm_stall(s_stall), .soma_vm_rvld(s_rvld), .soma_vm_rdata(s_rdata),
    .config_soma_vm_we(c_we), .config_soma_vm_waddr(c_waddr), .config_soma_vm_wdata(c_wdata),
    .config_soma_vm_re(c_re), .config_soma_vm_raddr(c_raddr),
    .config_stall(c_stall), .config_rvld(c_rvld), .config_soma_vm_rdata(c_rdata),
    .mem_en(m_en), .mem_we(m_we), .mem_addr(m_addr), .mem_wdata(m_wdata), .mem_rdata(m_rdata)
  );

  soma_vm_arbiter #(.STARVE_MAX(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n),
    .soma_vm_we(1'b0), .soma_vm_waddr(12'h000), .soma_vm_wdata(20'h00000),
    .soma_vm_re(z_s_re), .soma_vm_raddr(z_s_raddr),
    .soma_vm_stall(z_s_stall), .soma_vm_rvld(z_s_rvld), .soma_vm_rdata(z_s_rdata),
    .config_soma_vm_we(1'b0), .config_soma_vm_waddr(12'h000), .config_soma_vm_wdata(20'h00000),
    .config_soma_vm_re(z_c_re), .config_soma_vm_raddr(z_c_raddr),
    .config_stall(z_c_stall), .config_rvld(z_c_rvld), .config_soma_vm_rdata(z_c_rdata),
    .mem_en(z_en), .mem_we(z_we), .mem_addr(z_addr), .mem_wdata(z_wdata), .mem_rdata(z_rdata)
  );

  // SRAM models, preloaded with {8'hA5, addr} on the first clock.
  logic [19:0] mem_a [0:4095];
  logic [19:0] mem_z [0:4095];
  logic        init_done = 1'b0;
  int          wr3_cnt = 0;

  always @(posedge clk) begin
    if (!init_done) begin
      for (int i = 0; i < 4096; i++) begin
        mem_a[i] <= {8'hA5, i[11:0]};
        mem_z[i] <= {8'hA5, i[11:0]};
      end
      init_done <= 1'b1;
      m_rdata   <= '0;
      z_rdata   <= '0;
    end else begin
      if (m_en) begin
        if (m_we) mem_a[m_addr] <= m_wdata;
        else      m_rdata <= mem_a[m_addr];
      end
      if (z_en) begin
        if (z_we) mem_z[z_addr] <= z_wdata;
        else      z_rdata <= mem_z[z_addr];
      end
      if (m_en && m_we && m_addr == 12'h003) wr3_cnt <= wr3_cnt + 1;
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [19:0] pat(input logic [11:0] a);
    return {8'hA5, a};
  endfunction

  // Scoreboard queues of expected read returns.
  logic [19:0] exp_s[$], exp_c[$], exp_zs[$], exp_zc[$];

  task automatic pop_chk(input string name, input logic [19:0] act, inout logic [19:0] q[$]);
    if (q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s: unexpected rvld with data %0h, expected none", name, act);
    end else begin
      chk(name, act, q.pop_front());
    end
  endtask

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (s_rvld)   pop_chk("soma_rdata", s_rdata, exp_s);
      if (c_rvld)   pop_chk("cfg_rdata", c_rdata, exp_c);
      if (z_s_rvld) pop_chk("z_soma_rdata", z_s_rdata, exp_zs);
      if (z_c_rvld) pop_chk("z_cfg_rdata", z_c_rdata, exp_zc);
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete, expected finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    s_we = 0; s_re = 0; c_we = 0; c_re = 0;
    s_waddr = 0; s_raddr = 0; c_waddr = 0; c_raddr = 0;
    s_wdata = 0; c_wdata = 0;
    z_s_re = 0; z_c_re = 0; z_s_raddr = 0; z_c_raddr = 0;
    repeat (3) @(negedge clk);
    chk("rst_soma_rvld", s_rvld, 0);
    chk("rst_cfg_rvld", c_rvld, 0);
    chk("rst_soma_rdata", s_rdata, 0);
    chk("rst_cfg_rdata", c_rdata, 0);
    chk("rst_mem_en", m_en, 0);
    chk("rst_stalls", {s_stall, c_stall, z_s_stall, z_c_stall}, 0);
    rst_n = 1'b1;

    // Contention: soma reads 0..7, config read 0x010 held; forced on 5th cycle.
    for (int c = 0; c < 9; c++) begin
      @(negedge clk);
      s_re = 1'b1;
      s_raddr = (c <= 4) ? 12'(c) : 12'(c - 1);
      c_re = (c <= 4);
      c_raddr = 12'h010;
      #1;
      chk($sformatf("cont_soma_stall_%0d", c), s_stall, (c == 4));
      chk($sformatf("cont_cfg_stall_%0d", c), c_stall, (c < 4));
      chk($sformatf("cont_mem_addr_%0d", c), m_addr, (c == 4) ? 12'h010 : s_raddr);
      if (c == 4) exp_c.push_back(pat(12'h010));
      else        exp_s.push_back(pat(s_raddr));
    end
    @(negedge clk);
    s_re = 0; c_re = 0;

    // Config write then config read of 0x005.
    @(negedge clk);
    c_we = 1; c_waddr = 12'h005; c_wdata = 20'h12345;
    #1;
    chk("cw_mem_en", m_en, 1);
    chk("cw_mem_we", m_we, 1);
    chk("cw_mem_addr", m_addr, 12'h005);
    chk("cw_mem_wdata", m_wdata, 20'h12345);
    chk("cw_cfg_stall", c_stall, 0);
    @(negedge clk);
    c_we = 0; c_re = 1; c_raddr = 12'h005;
    exp_c.push_back(20'h12345);
    #1;
    chk("cr_mem_we", m_we, 0);
    chk("cr_mem_addr", m_addr, 12'h005);
    @(negedge clk);
    c_re = 0;
    #1;
    chk("idle_mem_en", m_en, 0);
    chk("idle_stalls", {s_stall, c_stall}, 0);
    chk("cr_soma_rvld", s_rvld, 0);

    // STARVE_MAX=0: config wins immediately.
    @(negedge clk);
    z_s_re = 1; z_s_raddr = 12'h001; z_c_re = 1; z_c_raddr = 12'h002;
    exp_zc.push_back(pat(12'h002));
    #1;
    chk("z_soma_stall", z_s_stall, 1);
    chk("z_cfg_stall", z_c_stall, 0);
    chk("z_addr0", z_addr, 12'h002);
    @(negedge clk);
    z_c_re = 0;
    exp_zs.push_back(pat(12'h001));
    #1;
    chk("z_soma_stall2", z_s_stall, 0);
    chk("z_addr1", z_addr, 12'h001);
    @(negedge clk);
    z_s_re = 0;

    // Soma write+read split.
    @(negedge clk);
    s_we = 1; s_waddr = 12'h003; s_wdata = 20'h00AAA; s_re = 1; s_raddr = 12'h004;
    #1;
    chk("wr_mem_we", m_we, 1);
    chk("wr_mem_addr", m_addr, 12'h003);
    chk("wr_mem_wdata", m_wdata, 20'h00AAA);
    chk("wr_soma_stall", s_stall, 1);
    @(negedge clk);
    exp_s.push_back(pat(12'h004));
    #1;
    chk("rd_mem_en", m_en, 1);
    chk("rd_mem_we", m_we, 0);
    chk("rd_mem_addr", m_addr, 12'h004);
    chk("rd_soma_stall", s_stall, 0);
    @(negedge clk);
    s_we = 0; s_raddr = 12'h003;
    exp_s.push_back(20'h00AAA);
    #1;
    chk("rb_mem_addr", m_addr, 12'h003);
    @(negedge clk);
    s_re = 0;
    chk("wr3_once", wr3_cnt, 1);

    // Config write+read together: write only, no rvld.
    @(negedge clk);
    c_we = 1; c_waddr = 12'h020; c_wdata = 20'h0BEEF; c_re = 1; c_raddr = 12'h021;
    #1;
    chk("cwr_mem_we", m_we, 1);
    chk("cwr_mem_addr", m_addr, 12'h020);
    chk("cwr_cfg_stall", c_stall, 0);
    @(negedge clk);
    c_we = 0; c_re = 0;
    @(negedge clk);
    c_re = 1; c_raddr = 12'h020;
    exp_c.push_back(20'h0BEEF);
    @(negedge clk);
    c_raddr = 12'h021;
    exp_c.push_back(pat(12'h021));
    @(negedge clk);
    c_re = 0;

    // Reset right after a granted soma read: no rvld.
    @(negedge clk);
    s_re = 1; s_raddr = 12'h005;
    @(posedge clk);
    #1;
    rst_n = 0;
    s_re = 0;
    @(negedge clk);
    chk("rstmid_soma_rvld", s_rvld, 0);
    chk("rstmid_soma_rdata", s_rdata, 0);
    rst_n = 1;
    @(negedge clk);
    chk("post_rst_outs", {m_en, m_we, s_stall, c_stall, s_rvld, c_rvld}, 0);
    chk("post_rst_rdata", {s_rdata, c_rdata}, 0);

    repeat (3) @(negedge clk);
    chk("exp_s_empty", exp_s.size(), 0);
    chk("exp_c_empty", exp_c.size(), 0);
    chk("exp_zs_empty", exp_zs.size(), 0);
    chk("exp_zc_empty", exp_zc.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
